// File: rtl/regr_feeder_if.sv
// Sample-write, frame-launch and accumulator handshake bundle for regr_feeder.
// The master side is the sample source and accumulators; the slave side is the feeder.
interface regr_feeder_if;
  logic        wr_valid;
  logic        wr_ready;
  logic [11:0] wr_x;
  logic [15:0] wr_y;
  logic        go;
  logic        acc_start;
  logic [11:0] acc_x12;
  logic [15:0] acc_x16;
  logic [15:0] acc_y;
  logic        xtx_valid;
  logic        xty_valid;
  logic        done;
  logic        err;
  logic [8:0]  fill;

  modport master (
    output wr_valid, wr_x, wr_y, go, xtx_valid, xty_valid,
    input  wr_ready, acc_start, acc_x12, acc_x16, acc_y, done, err, fill
  );

  modport slave (
    input  wr_valid, wr_x, wr_y, go, xtx_valid, xty_valid,
    output wr_ready, acc_start, acc_x12, acc_x16, acc_y, done, err, fill
  );
endinterface

// File: rtl/regr_feeder.sv
// Buffers one frame of N (x, y) samples, then streams it gap-free to the XTX/XTY
// accumulators and waits (with timeout) for both accumulator result pulses.
module regr_feeder #(
  parameter int unsigned N   = 256,
  parameter int unsigned TMO = 8
) (
  input  logic         clk,
  input  logic         rst,
  regr_feeder_if.slave bus
);
  localparam int unsigned AW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [2:0] {
    StLoad, StReady, StStart, StStream, StWait, StFin
  } state_e;

  state_e        state_q, state_d;
  logic [8:0]    fill_q, fill_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [15:0]   tmo_q, tmo_d;
  logic          xtx_q, xtx_d;
  logic          xty_q, xty_d;
  logic [27:0]   rd_q, rd_d;
  logic [27:0]   mem_q [N];
  logic          we;
  logic [AW-1:0] rd_addr;

  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    xtx_d   = xtx_q;
    xty_d   = xty_q;
    rd_d    = rd_q;
    we      = 1'b0;
    rd_addr = '0;
    unique case (state_q)
      StLoad: begin
        if (bus.wr_valid) begin
          we     = 1'b1;
          fill_d = fill_q + 9'd1;
          if (fill_d == 9'(N)) state_d = StReady;
        end
      end
      StReady: begin
        if (bus.go) state_d = StStart;
      end
      StStart: begin
        // Prefetch sample 0 so it is on the bus the cycle after acc_start.
        rd_addr = '0;
        rd_d    = mem_q[rd_addr];
        cnt_d   = '0;
        state_d = StStream;
      end
      StStream: begin
        // cnt_q is the sample being presented; fetch the next one behind it.
        rd_addr = cnt_q + AW'(1);
        rd_d    = mem_q[rd_addr];
        cnt_d   = cnt_q + AW'(1);
        if (cnt_q == AW'(N - 1)) begin
          state_d = StWait;
          tmo_d   = 16'(TMO);
        end
      end
      StWait: begin
        xtx_d = xtx_q | bus.xtx_valid;
        xty_d = xty_q | bus.xty_valid;
        tmo_d = tmo_q - 16'd1;
        if ((xtx_d && xty_d) || (tmo_q <= 16'd1)) state_d = StFin;
      end
      StFin: begin
        fill_d  = '0;
        xtx_d   = 1'b0;
        xty_d   = 1'b0;
        tmo_d   = '0;
        state_d = StLoad;
      end
      default: state_d = StLoad;
    endcase
  end

  always_comb begin
    bus.wr_ready  = (state_q == StLoad);
    bus.acc_start = (state_q == StStart);
    bus.acc_x12   = '0;
    bus.acc_x16   = '0;
    bus.acc_y     = '0;
    if (state_q == StStream) begin
      bus.acc_x12 = rd_q[27:16];
      bus.acc_x16 = {4'b0000, rd_q[27:16]};
      bus.acc_y   = rd_q[15:0];
    end
    bus.done = (state_q == StFin) && xtx_q && xty_q;
    // Timeout fires in the last WAIT cycle unless the missing pulse arrives right then.
    bus.err  = (state_q == StWait) && (tmo_q <= 16'd1) && !(xtx_d && xty_d);
    bus.fill = fill_q;
  end

  always_ff @(posedge clk) begin
    if (we && !rst) mem_q[fill_q[AW-1:0]] <= {bus.wr_x, bus.wr_y};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StLoad;
      fill_q  <= '0;
      cnt_q   <= '0;
      tmo_q   <= '0;
      xtx_q   <= 1'b0;
      xty_q   <= 1'b0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      xtx_q   <= xtx_d;
      xty_q   <= xty_d;
      rd_q    <= rd_d;
    end
  end
endmodule

// File: tb/tb_regr_feeder.sv
// Directed bench for regr_feeder: table of accumulator-return scenarios per frame,
// plus hand sequences for write saturation and reset mid-stream.
module tb_regr_feeder;
  localparam int unsigned N    = 256;
  localparam int unsigned TMO  = 8;
  localparam int          NONE = 999;
  localparam int          NVEC = 8;

  // Delays are in cycles after the last streamed sample (that cycle is 0).
  typedef struct {
    int xtx_dly;
    int xty_dly;
    int exp_done;
    int exp_err;
  } vec_t;

  logic clk = 1'b0;
  logic rst;

  regr_feeder_if bus ();

  regr_feeder #(
    .N   (N),
    .TMO (TMO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [11:0] exp_x [N];
  logic [15:0] exp_y [N];
  vec_t        vecs  [NVEC];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    bus.wr_valid  = 1'b0;
    bus.go        = 1'b0;
    bus.xtx_valid = 1'b0;
    bus.xty_valid = 1'b0;
  endtask

  task automatic drive_valids(input vec_t v, input int d);
    bus.xtx_valid = (d == v.xtx_dly);
    bus.xty_valid = (d == v.xty_dly);
  endtask

  // Writes N samples with periodic idle cycles carrying a (to-be-ignored) go.
  task automatic load_frame(input int off);
    int k       = 0;
    int cyc     = 0;
    bit started = 1'b0;
    while (k < int'(N)) begin
      @(negedge clk);
      idle_inputs();
      if (cyc % 7 == 3) begin
        bus.go = 1'b1;
      end else begin
        exp_x[k]     = 12'(k * 7 + off);
        exp_y[k]     = 16'(k * 13 + off * 5);
        bus.wr_valid = 1'b1;
        bus.wr_x     = exp_x[k];
        bus.wr_y     = exp_y[k];
        if (k == int'(N) - 1) bus.go = 1'b1;
        k++;
      end
      #1;
      if (bus.acc_start) started = 1'b1;
      cyc++;
    end
    @(negedge clk);
    idle_inputs();
    #1;
    check("load_fill", int'(bus.fill), int'(N));
    check("load_wr_ready", int'(bus.wr_ready), 0);
    check("load_no_start", int'(started), 0);
  endtask

  task automatic stream_and_wait(input vec_t v);
    @(negedge clk);
    idle_inputs();
    bus.go = 1'b1;
    #1;
    check("ready_acc_start", int'(bus.acc_start), 0);
    @(negedge clk);
    idle_inputs();
    #1;
    check("acc_start", int'(bus.acc_start), 1);
    check("start_x12_zero", int'(bus.acc_x12), 0);
    for (int k = 0; k < int'(N); k++) begin
      @(negedge clk);
      idle_inputs();
      drive_valids(v, k - (int'(N) - 1));
      #1;
      check("stream_x12", int'(bus.acc_x12), int'(exp_x[k]));
      check("stream_x16", int'(bus.acc_x16), int'(exp_x[k]));
      check("stream_y", int'(bus.acc_y), int'(exp_y[k]));
      check("stream_start_low", int'(bus.acc_start), 0);
    end
    for (int d = 1; d <= 12; d++) begin
      @(negedge clk);
      idle_inputs();
      drive_valids(v, d);
      #1;
      check("wait_done", int'(bus.done), int'(d == v.exp_done));
      check("wait_err", int'(bus.err), int'(d == v.exp_err));
      if (d == 1) begin
        check("post_x12_zero", int'(bus.acc_x12), 0);
        check("post_x16_zero", int'(bus.acc_x16), 0);
        check("post_y_zero", int'(bus.acc_y), 0);
      end
    end
    check("fin_fill", int'(bus.fill), 0);
    check("fin_wr_ready", int'(bus.wr_ready), 1);
  endtask

  initial begin
    int  acc;
    bit  started;

    vecs[0] = '{5, 2, 6, NONE};
    vecs[1] = '{3, 3, 4, NONE};
    vecs[2] = '{1, NONE, NONE, 8};
    vecs[3] = '{NONE, NONE, NONE, 8};
    vecs[4] = '{8, 1, 9, NONE};
    vecs[5] = '{9, 1, NONE, 8};
    vecs[6] = '{0, 2, NONE, 8};
    vecs[7] = '{1, 1, 2, NONE};

    rst      = 1'b1;
    bus.wr_x = '0;
    bus.wr_y = '0;
    idle_inputs();
    repeat (2) @(negedge clk);
    #1;
    check("rst_wr_ready", int'(bus.wr_ready), 1);
    check("rst_fill", int'(bus.fill), 0);
    check("rst_acc_start", int'(bus.acc_start), 0);
    check("rst_x12", int'(bus.acc_x12), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_err", int'(bus.err), 0);
    rst = 1'b0;

    // wr_valid held for 300 cycles; go coincides with the Nth write.
    acc     = 0;
    started = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      idle_inputs();
      bus.wr_valid = 1'b1;
      bus.wr_x     = 12'(i);
      bus.wr_y     = 16'(3 * i);
      bus.go       = (i == 255);
      if (i < int'(N)) begin
        exp_x[i] = 12'(i);
        exp_y[i] = 16'(3 * i);
      end
      #1;
      if (bus.wr_ready) acc++;
      if (bus.acc_start) started = 1'b1;
      if (i == 255) check("sat_ready_255", int'(bus.wr_ready), 1);
      if (i == 256) begin
        check("sat_ready_256", int'(bus.wr_ready), 0);
        check("sat_fill_256", int'(bus.fill), 256);
      end
    end
    check("sat_accepted", acc, 256);
    check("sat_go_ignored", int'(started), 0);
    check("sat_fill", int'(bus.fill), 256);
    stream_and_wait(vecs[0]);

    for (int i = 1; i < NVEC; i++) begin
      load_frame(i * 11);
      stream_and_wait(vecs[i]);
    end

    // Reset at stream sample 100 aborts the frame.
    load_frame(40);
    @(negedge clk);
    idle_inputs();
    bus.go = 1'b1;
    @(negedge clk);
    idle_inputs();
    #1;
    check("abort_acc_start", int'(bus.acc_start), 1);
    for (int k = 0; k <= 100; k++) begin
      @(negedge clk);
      idle_inputs();
      if (k == 100) rst = 1'b1;
      #1;
      check("abort_stream_x12", int'(bus.acc_x12), int'(exp_x[k]));
      check("abort_stream_y", int'(bus.acc_y), int'(exp_y[k]));
    end
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    #1;
    check("abort_x12", int'(bus.acc_x12), 0);
    check("abort_x16", int'(bus.acc_x16), 0);
    check("abort_y", int'(bus.acc_y), 0);
    check("abort_acc_start_low", int'(bus.acc_start), 0);
    check("abort_fill", int'(bus.fill), 0);
    check("abort_wr_ready", int'(bus.wr_ready), 1);
    for (int d = 0; d < 12; d++) begin
      @(negedge clk);
      idle_inputs();
      bus.xtx_valid = (d % 3 == 0);
      bus.xty_valid = (d % 4 == 1);
      #1;
      check("abort_no_done", int'(bus.done), 0);
      check("abort_no_err", int'(bus.err), 0);
    end
    load_frame(77);
    stream_and_wait(vecs[0]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
